// File: rtl/ex_stage_md_if.sv
// Bundle of the ID/EX inputs and EX/MEM outputs of the multiply-capable execute stage.
// master drives the instruction side; slave is the execute stage itself.
interface ex_stage_md_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic              i_pipe_Valid;
  logic              i_pipe_Stall;
  logic              i_pipe_Flush;
  logic [XLEN-1:0]   i_pipe_PC;
  logic [XLEN-1:0]   i_pipe_Imm;
  logic [XLEN-1:0]   i_pipe_Reg1Data;
  logic [XLEN-1:0]   i_pipe_Reg2Data;
  logic [1:0]        i_fwd_ASel;
  logic [1:0]        i_fwd_BSel;
  logic [XLEN-1:0]   i_wb_Data;
  logic              i_pipe_Alu1Src;
  logic [1:0]        i_pipe_Alu2Src;
  logic [3:0]        i_pipe_AluCtr;
  logic [2:0]        i_pipe_BrFunct3;
  logic              i_pipe_Branch;
  logic              i_pipe_Jump;
  logic              i_pipe_Jalr;
  logic [REG_AW-1:0] i_pipe_RegDst;
  logic              i_pipe_MemToReg;
  logic              i_pipe_RegWrEn;
  logic              i_pipe_MemWrEn;
  logic              o_busy;
  logic              o_pipe_Valid;
  logic [XLEN-1:0]   o_pipe_AluResult;
  logic [XLEN-1:0]   o_pipe_Reg2Data;
  logic [XLEN-1:0]   o_pipe_TargetAddr;
  logic              o_pipe_Taken;
  logic [REG_AW-1:0] o_pipe_RegDst;
  logic              o_pipe_MemToReg;
  logic              o_pipe_RegWrEn;
  logic              o_pipe_MemWrEn;

  modport master (
    output i_pipe_Valid, i_pipe_Stall, i_pipe_Flush, i_pipe_PC, i_pipe_Imm,
           i_pipe_Reg1Data, i_pipe_Reg2Data, i_fwd_ASel, i_fwd_BSel, i_wb_Data,
           i_pipe_Alu1Src, i_pipe_Alu2Src, i_pipe_AluCtr, i_pipe_BrFunct3,
           i_pipe_Branch, i_pipe_Jump, i_pipe_Jalr, i_pipe_RegDst,
           i_pipe_MemToReg, i_pipe_RegWrEn, i_pipe_MemWrEn,
    input  o_busy, o_pipe_Valid, o_pipe_AluResult, o_pipe_Reg2Data,
           o_pipe_TargetAddr, o_pipe_Taken, o_pipe_RegDst, o_pipe_MemToReg,
           o_pipe_RegWrEn, o_pipe_MemWrEn
  );

  modport slave (
    input  i_pipe_Valid, i_pipe_Stall, i_pipe_Flush, i_pipe_PC, i_pipe_Imm,
           i_pipe_Reg1Data, i_pipe_Reg2Data, i_fwd_ASel, i_fwd_BSel, i_wb_Data,
           i_pipe_Alu1Src, i_pipe_Alu2Src, i_pipe_AluCtr, i_pipe_BrFunct3,
           i_pipe_Branch, i_pipe_Jump, i_pipe_Jalr, i_pipe_RegDst,
           i_pipe_MemToReg, i_pipe_RegWrEn, i_pipe_MemWrEn,
    output o_busy, o_pipe_Valid, o_pipe_AluResult, o_pipe_Reg2Data,
           o_pipe_TargetAddr, o_pipe_Taken, o_pipe_RegDst, o_pipe_MemToReg,
           o_pipe_RegWrEn, o_pipe_MemWrEn
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage with forwarding, branch resolution, pipeline control and an
// iterative shift-add multiplier (MUL/MULHU) that holds upstream while it runs.
module ex_stage_md #(
  parameter int              XLEN     = 32,
  parameter int              REG_AW   = 5,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  ex_stage_md_if.slave ex
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] LAST_BIT = SW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]   rs1_fwd, rs2_fwd, op_a, op_b, alu_res, jalr_sum, target, mul_res;
  logic [SW-1:0]     shamt;
  logic              br_cond, is_mul, start, busy;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier, m_store;
  logic [SW-1:0]     count;
  logic              m_hi, m_m2r, m_rwe, m_mwe;
  logic [REG_AW-1:0] m_rd;

  always_comb begin
    case (ex.i_fwd_ASel)
      2'd1:    rs1_fwd = ex.o_pipe_AluResult;
      2'd2:    rs1_fwd = ex.i_wb_Data;
      default: rs1_fwd = ex.i_pipe_Reg1Data;
    endcase
    case (ex.i_fwd_BSel)
      2'd1:    rs2_fwd = ex.o_pipe_AluResult;
      2'd2:    rs2_fwd = ex.i_wb_Data;
      default: rs2_fwd = ex.i_pipe_Reg2Data;
    endcase
    op_a = ex.i_pipe_Alu1Src ? ex.i_pipe_PC : rs1_fwd;
    case (ex.i_pipe_Alu2Src)
      2'd0:    op_b = ex.i_pipe_Imm;
      2'd1:    op_b = rs2_fwd;
      2'd2:    op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex.i_pipe_AluCtr)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a << shamt;
      4'd3:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd4:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd5:  alu_res = op_a ^ op_b;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $signed(op_a) >>> shamt;
      4'd8:  alu_res = op_a | op_b;
      4'd9:  alu_res = op_a & op_b;
      4'd10: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (ex.i_pipe_BrFunct3)
      3'b000: br_cond = (rs1_fwd == rs2_fwd);
      3'b001: br_cond = (rs1_fwd != rs2_fwd);
      3'b100: br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      3'b101: br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110: br_cond = (rs1_fwd <  rs2_fwd);
      3'b111: br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_fwd + ex.i_pipe_Imm;
  assign target   = ex.i_pipe_Jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex.i_pipe_PC + ex.i_pipe_Imm;
  assign is_mul   = (ex.i_pipe_AluCtr == 4'd11) || (ex.i_pipe_AluCtr == 4'd12);
  assign start    = (state_q == IDLE) && ex.i_pipe_Valid && !ex.i_pipe_Flush && is_mul;
  assign mul_res  = m_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // busy covers the entry cycle too, so ID/EX keeps the multiply until DONE releases it
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        busy    = 1'b1;
      end
      BUSY: begin
        busy = 1'b1;
        if (count == LAST_BIT) state_d = DONE;
      end
      DONE: begin
        busy = ex.i_pipe_Stall;
        if (!ex.i_pipe_Stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex.i_pipe_Flush) state_d = IDLE;
  end

  assign ex.o_busy = busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      m_hi    <= 1'b0;
      m_store <= '0;
      m_rd    <= '0;
      m_m2r   <= 1'b0;
      m_rwe   <= 1'b0;
      m_mwe   <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{XLEN{1'b0}}, op_a};
      mplier  <= op_b;
      count   <= '0;
      m_hi    <= (ex.i_pipe_AluCtr == 4'd12);
      m_store <= rs2_fwd;
      m_rd    <= ex.i_pipe_RegDst;
      m_m2r   <= ex.i_pipe_MemToReg;
      m_rwe   <= ex.i_pipe_RegWrEn;
      m_mwe   <= ex.i_pipe_MemWrEn;
    end else if (state_q == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + SW'(1);
    end
  end

  // Bubbles clear only the qualifying bits; data fields keep their last value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex.o_pipe_Valid      <= 1'b0;
      ex.o_pipe_AluResult  <= '0;
      ex.o_pipe_Reg2Data   <= '0;
      ex.o_pipe_TargetAddr <= PC_RESET;
      ex.o_pipe_Taken      <= 1'b0;
      ex.o_pipe_RegDst     <= '0;
      ex.o_pipe_MemToReg   <= 1'b0;
      ex.o_pipe_RegWrEn    <= 1'b0;
      ex.o_pipe_MemWrEn    <= 1'b0;
    end else if (ex.i_pipe_Flush) begin
      ex.o_pipe_Valid   <= 1'b0;
      ex.o_pipe_Taken   <= 1'b0;
      ex.o_pipe_RegWrEn <= 1'b0;
      ex.o_pipe_MemWrEn <= 1'b0;
    end else if (!ex.i_pipe_Stall) begin
      if (state_q == IDLE && ex.i_pipe_Valid && !is_mul) begin
        ex.o_pipe_Valid      <= 1'b1;
        ex.o_pipe_AluResult  <= alu_res;
        ex.o_pipe_Reg2Data   <= rs2_fwd;
        ex.o_pipe_TargetAddr <= target;
        ex.o_pipe_Taken      <= ex.i_pipe_Jump | (ex.i_pipe_Branch & br_cond);
        ex.o_pipe_RegDst     <= ex.i_pipe_RegDst;
        ex.o_pipe_MemToReg   <= ex.i_pipe_MemToReg;
        ex.o_pipe_RegWrEn    <= ex.i_pipe_RegWrEn;
        ex.o_pipe_MemWrEn    <= ex.i_pipe_MemWrEn;
      end else if (state_q == DONE) begin
        ex.o_pipe_Valid     <= 1'b1;
        ex.o_pipe_AluResult <= mul_res;
        ex.o_pipe_Reg2Data  <= m_store;
        ex.o_pipe_Taken     <= 1'b0;
        ex.o_pipe_RegDst    <= m_rd;
        ex.o_pipe_MemToReg  <= m_m2r;
        ex.o_pipe_RegWrEn   <= m_rwe;
        ex.o_pipe_MemWrEn   <= m_mwe;
      end else begin
        ex.o_pipe_Valid   <= 1'b0;
        ex.o_pipe_Taken   <= 1'b0;
        ex.o_pipe_RegWrEn <= 1'b0;
        ex.o_pipe_MemWrEn <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed scenarios plus randomized
// single-cycle traffic compared against an arithmetic reference model.
module tb_ex_stage_md;
  localparam int XLEN = 32;
  localparam logic [31:0] PC_RST = 32'h0000_0400;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_stage_md_if #(.XLEN(XLEN), .REG_AW(5)) bus ();

  ex_stage_md #(.XLEN(XLEN), .REG_AW(5), .PC_RESET(PC_RST)) dut (
    .clk(clk), .reset_n(reset_n), .ex(bus)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [63:0] sext;
    int sh;
    sh   = b % 32;
    prod = {32'h0, a} * {32'h0, b};
    sext = {{32{a[31]}}, a};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * (32'h1 << sh);
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a / (32'h1 << sh);
      4'd7:  return 32'(sext >> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return prod[31:0];
      4'd12: return prod[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return !($signed(a) < $signed(b));
      3'b110: return a < b;
      3'b111: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    bus.i_pipe_Valid = 0; bus.i_pipe_Stall = 0; bus.i_pipe_Flush = 0;
    bus.i_pipe_PC = 0; bus.i_pipe_Imm = 0; bus.i_pipe_Reg1Data = 0; bus.i_pipe_Reg2Data = 0;
    bus.i_fwd_ASel = 0; bus.i_fwd_BSel = 0; bus.i_wb_Data = 0;
    bus.i_pipe_Alu1Src = 0; bus.i_pipe_Alu2Src = 0; bus.i_pipe_AluCtr = 0; bus.i_pipe_BrFunct3 = 0;
    bus.i_pipe_Branch = 0; bus.i_pipe_Jump = 0; bus.i_pipe_Jalr = 0;
    bus.i_pipe_RegDst = 0; bus.i_pipe_MemToReg = 0; bus.i_pipe_RegWrEn = 0; bus.i_pipe_MemWrEn = 0;
  endtask

  task automatic set_op(input logic [3:0] ctr, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [1:0] a2src);
    set_nop();
    bus.i_pipe_Valid = 1; bus.i_pipe_AluCtr = ctr;
    bus.i_pipe_Reg1Data = r1; bus.i_pipe_Reg2Data = r2; bus.i_pipe_Imm = imm; bus.i_pipe_PC = pc;
    bus.i_pipe_Alu2Src = a2src; bus.i_pipe_RegDst = 5'd7; bus.i_pipe_RegWrEn = 1;
  endtask

  task automatic test_reset();
    set_nop();
    #2 reset_n = 0;
    tick(); tick();
    checks++; if (bus.o_pipe_TargetAddr !== PC_RST) begin failures++; $display("FAIL rst_target got=%h exp=%h", bus.o_pipe_TargetAddr, PC_RST); end
    checks++; if (bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.o_pipe_Valid); end
    #4 reset_n = 1;
    tick();
    set_op(4'd11, 32'h1234, 32'h5678, 0, 0, 2'd1);
    #1;
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL mul_entry_busy got=%b exp=1", bus.o_busy); end
    repeat (5) tick();
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL mul_mid_busy got=%b exp=1", bus.o_busy); end
    #1 reset_n = 0;
    set_nop();
    #1;
    checks++; if (bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", bus.o_pipe_Valid); end
    checks++; if (bus.o_pipe_AluResult !== 32'h0) begin failures++; $display("FAIL arst_result got=%h exp=0", bus.o_pipe_AluResult); end
    checks++; if (bus.o_pipe_Reg2Data !== 32'h0) begin failures++; $display("FAIL arst_reg2 got=%h exp=0", bus.o_pipe_Reg2Data); end
    checks++; if (bus.o_pipe_TargetAddr !== PC_RST) begin failures++; $display("FAIL arst_target got=%h exp=%h", bus.o_pipe_TargetAddr, PC_RST); end
    checks++; if ({bus.o_pipe_Taken, bus.o_pipe_MemToReg, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn} !== 4'b0) begin
      failures++; $display("FAIL arst_flags got=%b exp=0000", {bus.o_pipe_Taken, bus.o_pipe_MemToReg, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn}); end
    checks++; if (bus.o_pipe_RegDst !== 5'd0) begin failures++; $display("FAIL arst_rd got=%0d exp=0", bus.o_pipe_RegDst); end
    #2 reset_n = 1;
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%b exp=0", bus.o_busy); end
    set_op(4'd0, 32'd3, 32'd4, 0, 0, 2'd1);
    tick();
    checks++; if (bus.o_pipe_Valid !== 1'b1) begin failures++; $display("FAIL post_rst_add_valid got=%b exp=1", bus.o_pipe_Valid); end
    checks++; if (bus.o_pipe_AluResult !== 32'd7) begin failures++; $display("FAIL post_rst_add got=%h exp=7", bus.o_pipe_AluResult); end
  endtask

  task automatic test_forward();
    set_op(4'd0, 32'h10, 0, 0, 0, 2'd3);
    tick();
    checks++; if (bus.o_pipe_AluResult !== 32'h10) begin failures++; $display("FAIL fwd_seed got=%h exp=10", bus.o_pipe_AluResult); end
    set_op(4'd1, 32'hDEAD, 32'd5, 0, 0, 2'd1); bus.i_fwd_ASel = 2'd1;
    tick();
    checks++; if (bus.o_pipe_AluResult !== 32'h0B) begin failures++; $display("FAIL fwd_mem_sub got=%h exp=0b", bus.o_pipe_AluResult); end
    set_op(4'd0, 32'hDEAD, 0, 32'd1, 0, 2'd0); bus.i_fwd_ASel = 2'd2; bus.i_wb_Data = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.o_pipe_AluResult !== 32'h0) begin failures++; $display("FAIL fwd_wb_add got=%h exp=0", bus.o_pipe_AluResult); end
    set_op(4'd10, 0, 32'h55, 0, 0, 2'd1); bus.i_fwd_BSel = 2'd2; bus.i_wb_Data = 32'hCAFE_0000;
    tick();
    checks++; if (bus.o_pipe_Reg2Data !== 32'hCAFE_0000) begin failures++; $display("FAIL fwd_wb_store got=%h exp=cafe0000", bus.o_pipe_Reg2Data); end
    set_op(4'd0, 32'd1, 32'h77, 0, 0, 2'd1); bus.i_fwd_BSel = 2'd1;
    tick();
    checks++; if (bus.o_pipe_AluResult !== 32'hCAFE_0001) begin failures++; $display("FAIL fwd_mem_b got=%h exp=cafe0001", bus.o_pipe_AluResult); end
    checks++; if (bus.o_pipe_Reg2Data !== 32'hCAFE_0000) begin failures++; $display("FAIL fwd_mem_store got=%h exp=cafe0000", bus.o_pipe_Reg2Data); end
  endtask

  task automatic test_branch();
    set_op(4'd0, 32'hFFFF_FFFE, 32'd1, 32'h20, 32'h100, 2'd1); bus.i_pipe_Branch = 1; bus.i_pipe_BrFunct3 = 3'b100;
    tick();
    checks++; if (bus.o_pipe_Taken !== 1'b1) begin failures++; $display("FAIL blt_taken got=%b exp=1", bus.o_pipe_Taken); end
    checks++; if (bus.o_pipe_TargetAddr !== 32'h120) begin failures++; $display("FAIL blt_target got=%h exp=120", bus.o_pipe_TargetAddr); end
    bus.i_pipe_BrFunct3 = 3'b110;
    tick();
    checks++; if (bus.o_pipe_Taken !== 1'b0) begin failures++; $display("FAIL bltu_taken got=%b exp=0", bus.o_pipe_Taken); end
    set_op(4'd0, 32'd9, 32'd9, 32'h20, 32'h100, 2'd1); bus.i_pipe_Branch = 1; bus.i_pipe_BrFunct3 = 3'b010;
    tick();
    checks++; if (bus.o_pipe_Taken !== 1'b0) begin failures++; $display("FAIL br_badf3_taken got=%b exp=0", bus.o_pipe_Taken); end
    set_op(4'd0, 32'h203, 0, 0, 32'h500, 2'd2); bus.i_pipe_Alu1Src = 1; bus.i_pipe_Jump = 1; bus.i_pipe_Jalr = 1;
    tick();
    checks++; if (bus.o_pipe_TargetAddr !== 32'h202) begin failures++; $display("FAIL jalr_target got=%h exp=202", bus.o_pipe_TargetAddr); end
    checks++; if (bus.o_pipe_Taken !== 1'b1) begin failures++; $display("FAIL jalr_taken got=%b exp=1", bus.o_pipe_Taken); end
    checks++; if (bus.o_pipe_AluResult !== 32'h504) begin failures++; $display("FAIL jalr_link got=%h exp=504", bus.o_pipe_AluResult); end
    bus.i_pipe_Valid = 0; bus.i_pipe_MemWrEn = 1;
    tick();
    checks++; if ({bus.o_pipe_Valid, bus.o_pipe_Taken, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn} !== 4'b0) begin
      failures++; $display("FAIL invalid_bubble got=%b exp=0000", {bus.o_pipe_Valid, bus.o_pipe_Taken, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn}); end
  endtask

  task automatic test_random();
    logic [31:0] r1, r2, imm, pc, wb, af, bf, oa, ob, jsum;
    logic [31:0] e_res, e_r2, e_tgt;
    logic [4:0]  e_rd;
    logic        e_valid, e_taken, e_m2r, e_rwe, e_mwe, res_known, stall;
    logic [3:0]  ctr;
    logic [1:0]  asel, bsel, a2;
    logic [2:0]  f3;
    logic        a1, br, jmp, jalr;
    res_known = 0;
    e_res = 0; e_r2 = 0; e_tgt = 0; e_rd = 0; e_valid = 0; e_taken = 0; e_m2r = 0; e_rwe = 0; e_mwe = 0;
    for (int i = 0; i < 300; i++) begin
      r1 = $urandom; r2 = $urandom; imm = $urandom; pc = $urandom; wb = $urandom;
      if ($urandom_range(0, 3) == 0) r2 = r1;
      asel = 2'($urandom_range(0, 3)); bsel = 2'($urandom_range(0, 3));
      if (!res_known && asel == 2'd1) asel = 2'd0;
      if (!res_known && bsel == 2'd1) bsel = 2'd0;
      ctr = 4'($urandom_range(0, 13));
      if (ctr >= 4'd11) ctr = ctr + 4'd2;
      a1 = 1'($urandom); a2 = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
      br = 1'($urandom); jmp = 1'($urandom); jalr = jmp & 1'($urandom);
      stall = (i > 0) && ($urandom_range(0, 3) == 0);
      set_nop();
      bus.i_pipe_Valid = 1; bus.i_pipe_Stall = stall;
      bus.i_pipe_Reg1Data = r1; bus.i_pipe_Reg2Data = r2; bus.i_pipe_Imm = imm; bus.i_pipe_PC = pc;
      bus.i_wb_Data = wb; bus.i_fwd_ASel = asel; bus.i_fwd_BSel = bsel;
      bus.i_pipe_Alu1Src = a1; bus.i_pipe_Alu2Src = a2; bus.i_pipe_AluCtr = ctr; bus.i_pipe_BrFunct3 = f3;
      bus.i_pipe_Branch = br; bus.i_pipe_Jump = jmp; bus.i_pipe_Jalr = jalr;
      bus.i_pipe_RegDst = 5'($urandom); bus.i_pipe_MemToReg = 1'($urandom);
      bus.i_pipe_RegWrEn = 1'($urandom); bus.i_pipe_MemWrEn = 1'($urandom);
      af = (asel == 2'd1) ? e_res : (asel == 2'd2) ? wb : r1;
      bf = (bsel == 2'd1) ? e_res : (bsel == 2'd2) ? wb : r2;
      oa = a1 ? pc : af;
      ob = (a2 == 2'd0) ? imm : (a2 == 2'd1) ? bf : (a2 == 2'd2) ? 32'd4 : 32'd0;
      jsum = af + imm;
      if (!stall) begin
        e_valid = 1; e_res = ref_alu(ctr, oa, ob); e_r2 = bf;
        e_tgt = jalr ? (jsum & 32'hFFFF_FFFE) : (pc + imm);
        e_taken = jmp | (br & ref_cond(f3, af, bf));
        e_rd = bus.i_pipe_RegDst; e_m2r = bus.i_pipe_MemToReg; e_rwe = bus.i_pipe_RegWrEn; e_mwe = bus.i_pipe_MemWrEn;
        res_known = 1;
      end
      tick();
      checks++; if (bus.o_pipe_Valid !== e_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.o_pipe_Valid, e_valid); end
      checks++; if (bus.o_pipe_AluResult !== e_res) begin failures++; $display("FAIL rnd_result[%0d] op=%0d got=%h exp=%h", i, ctr, bus.o_pipe_AluResult, e_res); end
      checks++; if (bus.o_pipe_Reg2Data !== e_r2) begin failures++; $display("FAIL rnd_reg2[%0d] got=%h exp=%h", i, bus.o_pipe_Reg2Data, e_r2); end
      checks++; if (bus.o_pipe_TargetAddr !== e_tgt) begin failures++; $display("FAIL rnd_target[%0d] got=%h exp=%h", i, bus.o_pipe_TargetAddr, e_tgt); end
      checks++; if (bus.o_pipe_Taken !== e_taken) begin failures++; $display("FAIL rnd_taken[%0d] f3=%0d got=%b exp=%b", i, f3, bus.o_pipe_Taken, e_taken); end
      checks++; if ({bus.o_pipe_RegDst, bus.o_pipe_MemToReg, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn} !== {e_rd, e_m2r, e_rwe, e_mwe}) begin
        failures++; $display("FAIL rnd_passthru[%0d] got=%h exp=%h", i, {bus.o_pipe_RegDst, bus.o_pipe_MemToReg, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn}, {e_rd, e_m2r, e_rwe, e_mwe}); end
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=0", i, bus.o_busy); end
    end
  endtask

  task automatic test_multiply();
    logic [31:0] a, b, exp;
    logic [3:0]  ctr;
    int busy_cycles, n;
    for (int k = 0; k < 5; k++) begin
      a = (k < 2) ? 32'hFFFF_FFFF : $urandom;
      b = (k < 2) ? 32'hFFFF_FFFF : $urandom;
      ctr = (k == 0) ? 4'd12 : (k == 1) ? 4'd11 : ($urandom_range(0, 1) == 1 ? 4'd12 : 4'd11);
      exp = ref_alu(ctr, a, b);
      set_op(ctr, a, b, 0, 0, 2'd1); bus.i_pipe_RegDst = 5'(k + 3);
      #1;
      busy_cycles = 0; n = 0;
      while (bus.o_busy && n < 100) begin
        if (n > 0) begin
          checks++; if (bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL mul_bubble[%0d] cyc=%0d got=%b exp=0", k, n, bus.o_pipe_Valid); end
        end
        busy_cycles++;
        tick();
        n++;
      end
      checks++; if (busy_cycles != 33) begin failures++; $display("FAIL mul_busy_len[%0d] got=%0d exp=33", k, busy_cycles); end
      set_nop();
      tick();
      checks++; if (bus.o_pipe_Valid !== 1'b1) begin failures++; $display("FAIL mul_valid[%0d] got=%b exp=1", k, bus.o_pipe_Valid); end
      checks++; if (bus.o_pipe_AluResult !== exp) begin failures++; $display("FAIL mul_result[%0d] op=%0d got=%h exp=%h", k, ctr, bus.o_pipe_AluResult, exp); end
      checks++; if (bus.o_pipe_RegDst !== 5'(k + 3) || bus.o_pipe_RegWrEn !== 1'b1 || bus.o_pipe_Taken !== 1'b0) begin
        failures++; $display("FAIL mul_ctrl[%0d] rd=%0d rwe=%b taken=%b exp rd=%0d rwe=1 taken=0", k, bus.o_pipe_RegDst, bus.o_pipe_RegWrEn, bus.o_pipe_Taken, k + 3); end
    end
  endtask

  task automatic test_stall_done();
    logic [31:0] a, b, exp;
    int busy_cycles, n;
    a = $urandom; b = $urandom;
    exp = ref_alu(4'd11, a, b);
    set_op(4'd11, a, b, 0, 0, 2'd1);
    #1;
    busy_cycles = 0; n = 0;
    while (bus.o_busy && n < 100) begin
      busy_cycles++;
      tick();
      n++;
      bus.i_pipe_Stall = (n >= 5 && n < 9);
      #1;
    end
    checks++; if (busy_cycles != 33) begin failures++; $display("FAIL stall_busy_len got=%0d exp=33", busy_cycles); end
    bus.i_pipe_Stall = 1;
    #1;
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL done_stall_busy got=%b exp=1", bus.o_busy); end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if ({bus.o_pipe_Valid, bus.o_pipe_RegWrEn, bus.o_pipe_Taken} !== 3'b0) begin
        failures++; $display("FAIL done_stall_hold[%0d] got=%b exp=000", s, {bus.o_pipe_Valid, bus.o_pipe_RegWrEn, bus.o_pipe_Taken}); end
      checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL done_stall_busy[%0d] got=%b exp=1", s, bus.o_busy); end
    end
    bus.i_pipe_Stall = 0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL done_release_busy got=%b exp=0", bus.o_busy); end
    set_nop();
    tick();
    checks++; if (bus.o_pipe_Valid !== 1'b1) begin failures++; $display("FAIL done_release_valid got=%b exp=1", bus.o_pipe_Valid); end
    checks++; if (bus.o_pipe_AluResult !== exp) begin failures++; $display("FAIL done_release_result got=%h exp=%h", bus.o_pipe_AluResult, exp); end
  endtask

  task automatic test_flush();
    set_op(4'd11, 32'h1357, 32'h2468, 0, 0, 2'd1);
    repeat (10) tick();
    set_nop(); bus.i_pipe_Flush = 1;
    tick();
    checks++; if (bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL flush_mul_valid got=%b exp=0", bus.o_pipe_Valid); end
    bus.i_pipe_Flush = 0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL flush_mul_busy got=%b exp=0", bus.o_busy); end
    tick();
    checks++; if (bus.o_busy !== 1'b0 || bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL flush_idle got busy=%b valid=%b exp 0/0", bus.o_busy, bus.o_pipe_Valid); end
    set_op(4'd0, 32'd3, 32'd9, 0, 0, 2'd1);
    tick();
    checks++; if (bus.o_pipe_Valid !== 1'b1 || bus.o_pipe_AluResult !== 32'd12) begin
      failures++; $display("FAIL flush_next_add got valid=%b res=%h exp 1/0000000c", bus.o_pipe_Valid, bus.o_pipe_AluResult); end
    set_op(4'd12, 32'h5, 32'h6, 0, 0, 2'd1); bus.i_pipe_Flush = 1;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", bus.o_busy); end
    tick();
    set_nop();
    #1;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_pipe_Valid !== 1'b0) begin failures++; $display("FAIL flush_start_after got busy=%b valid=%b exp 0/0", bus.o_busy, bus.o_pipe_Valid); end
    set_op(4'd0, 32'd5, 32'd6, 0, 0, 2'd1); bus.i_pipe_MemWrEn = 1;
    tick();
    set_op(4'd0, 32'd1, 32'd1, 0, 0, 2'd1); bus.i_pipe_Jump = 1; bus.i_pipe_Stall = 1; bus.i_pipe_Flush = 1;
    tick();
    checks++; if ({bus.o_pipe_Valid, bus.o_pipe_Taken, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn} !== 4'b0) begin
      failures++; $display("FAIL flush_over_stall got=%b exp=0000", {bus.o_pipe_Valid, bus.o_pipe_Taken, bus.o_pipe_RegWrEn, bus.o_pipe_MemWrEn}); end
    set_nop();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_branch();
    test_random();
    test_multiply();
    test_stall_done();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
